// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Pure declarations with no logic, no latency and no flow control.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PERIPH    = 2'd1,
    CPU       = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOCK_LOSS_W = 8;

  // Ceiling log2, with clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button path: 2-FF synchroniser then debounce. The level changes BTN_DEBOUNCE
// edges after the synced input first differs. No backpressure; the level is always valid.
module btn_debounce
  import rst_seq_pkg::*;
#(
  parameter int BTN_DEBOUNCE = 65536
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_btn_n_deb
);

  localparam int DW = clog2(BTN_DEBOUNCE) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [DW-1:0] r_dcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DW'(BTN_DEBOUNCE - 1)) begin
        r_deb  <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  assign o_btn_n_deb = r_deb;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: peripherals on edge L+P, then CPU and sys_ready on edge L+P+C.
// No backpressure; a lock loss or a debounced button press aborts to WAIT_LOCK on the next edge.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_HOLD        = 16,
  parameter int CPU_DELAY          = 16,
  parameter int BTN_DEBOUNCE       = 65536
) (
  input  logic                   clock_in,
  input  logic                   rst_n_in,
  input  logic                   locked_in,
  input  logic                   btn_n_in,
  output logic                   periph_rst_n,
  output logic                   cpu_rst_n,
  output logic                   sys_ready,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam int MAX_PC = (PERIPH_HOLD > CPU_DELAY) ? PERIPH_HOLD : CPU_DELAY;
  localparam int MAX_ALL = (LOCK_STABLE_CYCLES > MAX_PC) ? LOCK_STABLE_CYCLES : MAX_PC;
  localparam int CNT_W = clog2(MAX_ALL) + 1;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     r_periph;
  logic                     r_cpu;
  logic                     r_ready;
  logic [LOCK_LOSS_W-1:0]   r_loss;
  logic                     w_periph_nxt;
  logic                     w_cpu_nxt;
  logic                     w_ready_nxt;
  logic [LOCK_LOSS_W-1:0]   w_loss_nxt;
  logic                     w_btn_n_deb;
  logic                     w_btn_pressed;
  logic                     w_abort;

  btn_debounce #(
    .BTN_DEBOUNCE (BTN_DEBOUNCE)
  ) u_btn_debounce (
    .i_clk       (clock_in),
    .i_rst_n     (rst_n_in),
    .i_btn_n     (btn_n_in),
    .o_btn_n_deb (w_btn_n_deb)
  );

  assign w_btn_pressed = !w_btn_n_deb;
  assign w_abort       = (r_state != WAIT_LOCK) && (!locked_in || w_btn_pressed);

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= WAIT_LOCK;
      r_cnt    <= '0;
      r_periph <= 1'b0;
      r_cpu    <= 1'b0;
      r_ready  <= 1'b0;
      r_loss   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_periph <= w_periph_nxt;
      r_cpu    <= w_cpu_nxt;
      r_ready  <= w_ready_nxt;
      r_loss   <= w_loss_nxt;
    end
  end

  // Abort is checked before any count-complete so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_abort) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (locked_in && !w_btn_pressed) begin
            if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
              w_state_nxt = PERIPH;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        PERIPH: begin
          if (r_cnt == CNT_W'(PERIPH_HOLD - 1)) begin
            w_state_nxt = CPU;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        CPU: begin
          if (r_cnt == CNT_W'(CPU_DELAY - 1)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output registers follow the state being entered, so releases land on the transition edge.
  always_comb begin
    w_periph_nxt = (w_state_nxt == CPU) || (w_state_nxt == RUN);
    w_cpu_nxt    = (w_state_nxt == RUN);
    w_ready_nxt  = (w_state_nxt == RUN);
    w_loss_nxt   = r_loss;
    if (w_abort && !locked_in && (r_loss != {LOCK_LOSS_W{1'b1}})) begin
      w_loss_nxt = r_loss + 1'b1;
    end
  end

  assign periph_rst_n  = r_periph;
  assign cpu_rst_n     = r_cpu;
  assign sys_ready     = r_ready;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with L=8, P=4, C=4, D=4; expected release edges are queued at stimulus time.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  localparam int L = 8;
  localparam int P = 4;
  localparam int C = 4;
  localparam int D = 4;

  typedef struct {
    int periph_edge;
    int cpu_edge;
  } exp_t;

  logic       clock_in;
  logic       rst_n_in;
  logic       locked_in;
  logic       btn_n_in;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic       sys_ready;
  logic [7:0] lock_loss_cnt;

  int   n_checks;
  int   n_fail;
  int   edge_cnt;
  int   exp_loss;
  int   base;
  int   drops;
  exp_t exp_q[$];

  rst_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .PERIPH_HOLD        (P),
    .CPU_DELAY          (C),
    .BTN_DEBOUNCE       (D)
  ) dut (
    .clock_in      (clock_in),
    .rst_n_in      (rst_n_in),
    .locked_in     (locked_in),
    .btn_n_in      (btn_n_in),
    .periph_rst_n  (periph_rst_n),
    .cpu_rst_n     (cpu_rst_n),
    .sys_ready     (sys_ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
    edge_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input int loss);
    check({tag, ".periph"}, 32'(periph_rst_n), 32'(v));
    check({tag, ".cpu"}, 32'(cpu_rst_n), 32'(v));
    check({tag, ".ready"}, 32'(sys_ready), 32'(v));
    check({tag, ".loss"}, 32'(lock_loss_cnt), 32'(loss));
  endtask

  task automatic push_seq(input int b);
    exp_t e;
    e.periph_edge = b + L + P;
    e.cpu_edge    = b + L + P + C;
    exp_q.push_back(e);
  endtask

  // Pops the oldest expectation and waits (bounded) for the release edges.
  task automatic observe(input string tag);
    exp_t e;
    int   p_edge;
    int   c_edge;
    e      = exp_q.pop_front();
    p_edge = -1;
    c_edge = -1;
    for (int i = 0; i < 200 && c_edge < 0; i++) begin
      step();
      if (periph_rst_n === 1'b1 && p_edge < 0) p_edge = edge_cnt;
      if (cpu_rst_n === 1'b1 && c_edge < 0) c_edge = edge_cnt;
    end
    check({tag, ".periph_edge"}, 32'(p_edge), 32'(e.periph_edge));
    check({tag, ".cpu_edge"}, 32'(c_edge), 32'(e.cpu_edge));
    check({tag, ".ready"}, 32'(sys_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    edge_cnt  = 0;
    exp_loss  = 0;
    rst_n_in  = 1'b0;
    locked_in = 1'b1;
    btn_n_in  = 1'b1;

    repeat (3) step();
    check_outs("reset", 1'b0, 0);

    rst_n_in = 1'b1;
    push_seq(edge_cnt);
    observe("powerup");
    check("powerup.loss", 32'(lock_loss_cnt), 32'd0);

    locked_in = 1'b0;
    step();
    exp_loss++;
    check_outs("lockloss_run", 1'b0, exp_loss);
    locked_in = 1'b1;
    push_seq(edge_cnt);
    observe("reseq1");

    btn_n_in = 1'b0;
    repeat (3) step();
    btn_n_in = 1'b1;
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sys_ready !== 1'b1) drops++;
    end
    check("short_btn.drops", 32'(drops), 32'd0);

    btn_n_in = 1'b0;
    repeat (6) step();
    check("long_btn.before", 32'(sys_ready), 32'd1);
    step();
    check_outs("long_btn.abort", 1'b0, exp_loss);
    repeat (5) step();
    btn_n_in = 1'b1;
    push_seq(edge_cnt + 2 + D);
    observe("btn_release");
    check("btn_release.loss", 32'(lock_loss_cnt), 32'(exp_loss));

    locked_in = 1'b0;
    step();
    exp_loss++;
    locked_in = 1'b1;
    repeat (L + P + 2) step();
    check("mid_cpu.periph", 32'(periph_rst_n), 32'd1);
    check("mid_cpu.cpu", 32'(cpu_rst_n), 32'd0);
    locked_in = 1'b0;
    step();
    exp_loss++;
    check_outs("mid_cpu.abort", 1'b0, exp_loss);

    locked_in = 1'b1;
    repeat (L + P + C - 1) step();
    check("last_cpu.cpu", 32'(cpu_rst_n), 32'd0);
    locked_in = 1'b0;
    step();
    exp_loss++;
    check_outs("last_cpu.abort_wins", 1'b0, exp_loss);
    locked_in = 1'b1;
    push_seq(edge_cnt);
    observe("reseq2");

    for (int i = 0; i < 300; i++) begin
      locked_in = 1'b0;
      step();
      if (exp_loss < 255) exp_loss++;
      locked_in = 1'b1;
      repeat (L + P + C) step();
    end
    check("saturate.loss", 32'(lock_loss_cnt), 32'(exp_loss));
    check("saturate.ready", 32'(sys_ready), 32'd1);

    #3;
    rst_n_in  = 1'b0;
    locked_in = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 0);
    repeat (2) step();
    rst_n_in  = 1'b1;
    locked_in = 1'b1;
    repeat (5) step();
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    push_seq(edge_cnt);
    observe("glitch");
    check("glitch.loss", 32'(lock_loss_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly downstream of the PLL wrapper and runs in the PLL output clock domain.
- Consumes the PLL's synchronised lock flag and a raw board reset button.
- Produces staged, synchronously-deasserted resets: peripherals first, then CPU core, then a system-ready flag.
- Re-enters reset whenever lock is lost or the button is pressed, and counts lock-loss events for debug.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive cycles locked_in must be high before release starts (min 1).
- PERIPH_HOLD, 16: cycles periph_rst_n stays asserted after lock is qualified (min 1).
- CPU_DELAY, 16: cycles between periph_rst_n release and cpu_rst_n release (min 1).
- BTN_DEBOUNCE, 65536: cycles the synchronised button must be stable before the debounced value changes (min 1).

Ports:
- clock_in  input  1  PLL output clock; the only clock.
- rst_n_in  input  1  asynchronous active-low reset.
- locked_in  input  1  PLL lock, already synchronised to clock_in.
- btn_n_in  input  1  raw board reset button, active-low, asynchronous.
- periph_rst_n  output  1  peripheral reset, active-low, registered.
- cpu_rst_n  output  1  CPU reset, active-low, registered.
- sys_ready  output  1  high only in RUN, registered.
- lock_loss_cnt  output  8  saturating count of lock losses after qualification.

Behaviour:
- Reset (rst_n_in=0, async):
  - state=WAIT_LOCK, cnt=0.
  - periph_rst_n=0, cpu_rst_n=0, sys_ready=0, lock_loss_cnt=0.
  - Button sync FFs and debounced value = 1 (released).
- All outputs are registered; deassertion is synchronous to clock_in by construction.
- Button path:
  - 2-FF synchroniser on btn_n_in, then debounce counter.
  - Counter increments while the synced value differs from the debounced value and clears when they match.
  - At BTN_DEBOUNCE-1 the debounced value takes the synced value and the counter clears.
  - btn_pressed = (debounced == 0).
- Single shared counter cnt, width = clog2(max(LOCK_STABLE_CYCLES, PERIPH_HOLD, CPU_DELAY)) + 1.
- State WAIT_LOCK:
  - Both resets asserted, sys_ready=0.
  - If locked_in=1 and !btn_pressed: cnt++. Otherwise cnt=0.
  - When cnt==LOCK_STABLE_CYCLES-1 and locked_in=1 and !btn_pressed: go to PERIPH, cnt=0.
  - This fires on the LOCK_STABLE_CYCLES-th consecutive qualifying edge.
- State PERIPH:
  - cnt++ each edge.
  - At cnt==PERIPH_HOLD-1: go to CPU, cnt=0, periph_rst_n<=1 on the same edge.
- State CPU:
  - cnt++ each edge.
  - At cnt==CPU_DELAY-1: go to RUN, cpu_rst_n<=1 and sys_ready<=1 on the same edge.
- State RUN: hold all released.
- Abort, from PERIPH, CPU or RUN, when locked_in=0 or btn_pressed:
  - Next edge: state=WAIT_LOCK, cnt=0, periph_rst_n=0, cpu_rst_n=0, sys_ready=0.
  - Abort takes priority over any count-complete transition on the same edge.
- Latency: numbering the first qualifying edge as 1,
  - periph_rst_n rises on edge L+P;
  - cpu_rst_n and sys_ready rise on edge L+P+C.
- lock_loss_cnt:
  - Increments by 1 on any abort edge where locked_in=0, including when the button is also pressed.
  - Saturates at 255; cleared only by rst_n_in.
  - Button-only aborts do not count.
  - Lock drops while in WAIT_LOCK do not count.
- Invariant: cpu_rst_n=1 implies periph_rst_n=1. sys_ready equals cpu_rst_n.
- A locked_in glitch in WAIT_LOCK restarts qualification from cnt=0. There is no partial credit.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum (WAIT_LOCK, PERIPH, CPU, RUN), 2 bits;
  - LOCK_LOSS_W=8;
  - clog2 helper function.
- One sub-module, btn_debounce (synchroniser plus debounce counter, parameter BTN_DEBOUNCE, output debounced level).

Test Plan (L=8, P=4, C=4, D=4):
- Power-up: release rst_n_in, hold locked_in=1 and button released → periph_rst_n rises on edge 12, cpu_rst_n and sys_ready on edge 16, lock_loss_cnt=0.
- Qualification glitch: locked_in high 5 cycles, low 1, then high → periph_rst_n rises 12 edges after re-rise, not earlier.
- Lock loss in RUN: drop locked_in for 1 cycle → all outputs 0 next edge, lock_loss_cnt=1, full L+P+C re-sequence afterwards. Repeat 300 times → count holds at 255.
- Button press in RUN, held 3 cycles: no effect. Held ≥ D plus sync delay: resets asserted, lock_loss_cnt unchanged. Release: re-sequence after debounce plus L+P+C.
- Abort mid-CPU state: drop lock at cnt=2 in CPU → periph_rst_n falls on the next edge, cpu_rst_n never rose, lock_loss_cnt increments.
- Async reset mid-RUN: assert rst_n_in between edges → outputs 0 immediately, no clock needed; lock_loss_cnt cleared.
